uart_bus_slave: RTL and testbench
=================================

# uart_bus_slave

Memory-mapped UART responder for the single-cycle MIPS core's data bus. It decodes CPU loads and stores in the peripheral window (address bit 30 set) and provides an 8N1 transmitter and receiver. It also provides a status/control register and a level interrupt back to the core. Reads are combinational so the core's same-cycle load completes; all side effects take effect on the clock edge that ends the access.

## Interface
- BASE_ADDR, 32'h40000018, byte address of TXD; RXD = BASE+4, CON = BASE+8
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer), DIV ≥ 4, DIV < 2^16
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mem_rd  in  1  CPU load strobe, one cycle per access
- mem_wr  in  1  CPU store strobe, one cycle per access
- addr  in  32  byte address from ALU; full 32-bit compare against the three register addresses
- wdata  in  32  store data; only [7:0] used
- rdata  out  32  load data, combinational; 0 unless mem_rd and an address hits
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output, registered
- irq  out  1  level interrupt to the core

## Operation
- TXD (RW): store with TX idle latches wdata[7:0] into tx_data and starts a frame, and clears tx_done. Store while tx_busy is ignored entirely. Load returns {24'b0, tx_data}.
- RXD (RO): load returns {24'b0, rx_data} and clears rx_valid and overrun at the edge. Stores are ignored.
- CON: bit0 tx_ie (RW), bit1 rx_ie (RW), bit2 tx_done (W1C), bit3 rx_valid (RO), bit4 tx_busy (RO), bit5 overrun (RO), bits 31:6 read 0.
- irq = (tx_ie & tx_done) | (rx_ie & rx_valid), combinational from registers.
- TX FSM: TX_IDLE → TX_START → TX_DATA (8 bits, LSB first) → TX_STOP → TX_IDLE.
  - Each state holds the line for exactly DIV cycles.
  - uart_tx = 1 in IDLE/STOP, 0 in START, and the current bit in DATA.
  - tx_busy = state ≠ TX_IDLE.
  - tx_done is set on the last cycle of STOP.
- RX path: uart_rx passes through a 2-flop synchronizer (rx_s).
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - IDLE: rx_s = 0 enters START, counter cleared.
  - START: after DIV/2 cycles, rx_s is sampled. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: 8 samples, each DIV cycles apart (mid-bit), shifted in LSB first.
  - STOP: sample after DIV cycles. If 1, rx_data ← shift register and rx_valid ← 1, and overrun ← 1 when rx_valid was already 1 (data is overwritten). If 0 (framing error), the byte is discarded with no flag change. Either way, return to IDLE.
- Simultaneous events:
  - Set beats clear: a completing RX byte in the same cycle as an RXD load leaves rx_valid = 1.
  - tx_done set in the same cycle as a W1C of tx_done leaves it 1.
  - A TXD store in the last STOP cycle is ignored, because busy is still high.
- mem_rd and mem_wr both high to the same address: the write takes effect and the read data reflects pre-edge state.

## Timing
- Reset (synchronous): uart_tx = 1, irq = 0, both FSMs idle, all counters 0. tx_data, rx_data, tx_ie, rx_ie, tx_done, rx_valid and overrun are all 0. Synchronizer flops are reset to 1.
- Reset mid-frame aborts immediately; uart_tx is 1 on the cycle after the reset edge.
- TXD store at edge E: uart_tx falls at E (registered output). The start bit occupies cycles E..E+DIV-1 and the frame occupies 10·DIV cycles. tx_busy falls and tx_done rises at edge E+10·DIV.
- RX latency: rx_valid rises 2 (synchronizer) + DIV/2 + 9·DIV cycles after the start-bit falling edge at the pin, ±1 cycle.
- rdata and irq have zero cycles of latency relative to register state. CON/RXD side effects are visible from the next cycle.

## Test plan
- Reset values: assert reset for 2 cycles mid-transmission → uart_tx = 1, irq = 0, CON reads 32'h0.
- TX frame, DIV = 16: store 8'hA5 to TXD.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles (LSB first).
  - CON bit4 = 1 during the frame.
  - CON reads 32'h4 after 160 cycles.
  - A second store of 8'h3C at cycle 50 is ignored, and TXD reads 8'hA5.
- RX frame: drive 8'h5A at DIV = 16 → RXD reads 32'h5A, CON bit3 = 1. With rx_ie = 1, irq = 1. Loading RXD drops irq the next cycle.
- Overrun and glitch:
  - Two frames 8'h11 then 8'h22 without reading → RXD = 8'h22, CON bit5 = 1.
  - A 3-cycle low pulse on uart_rx → no byte received.
- Framing error: frame 8'hFF with stop bit 0 → rx_valid remains 0 and rx_data is unchanged.
- Interrupt and W1C: tx_ie = 1 with a TX completion raises irq. Storing 32'h5 to CON keeps tx_ie = 1, clears tx_done and drops irq. Also drive a completion on the same edge as the W1C → tx_done stays 1.

Source files
------------

// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART for the MIPS data bus: TXD, RXD and CON registers
// with combinational loads, edge-applied side effects and a level interrupt.
module uart_bus_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq,
  output logic [1:0]  o_dbg_tx_state,
  output logic [1:0]  o_dbg_rx_state
);
  localparam int          DIV      = CLK_FREQ / BAUD;
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1  = 16'(DIV / 2 - 1);
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   r_tx_state, w_tx_next;
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_tx_cnt, w_tx_cnt_next, r_rx_cnt, w_rx_cnt_next;
  logic [2:0]  r_tx_bit, w_tx_bit_next, r_rx_bit, w_rx_bit_next;
  logic [7:0]  r_tx_data, r_rx_data, r_rx_shift, w_rx_shift_next;
  logic [1:0]  r_rx_sync;
  logic        r_uart_tx, w_tx_line, w_tx_done_set, w_rx_done;
  logic        r_tx_ie, r_rx_ie, r_tx_done, r_rx_valid, r_overrun;
  logic        w_hit_txd, w_hit_rxd, w_hit_con, w_txd_wr, w_rxd_rd, w_con_wr;
  logic        w_tx_busy, w_tx_end, w_rx_s;
  logic        w_unused;

  assign w_hit_txd = (addr == BASE_ADDR);
  assign w_hit_rxd = (addr == RXD_ADDR);
  assign w_hit_con = (addr == CON_ADDR);
  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign w_txd_wr  = mem_wr & w_hit_txd & ~w_tx_busy;
  assign w_rxd_rd  = mem_rd & w_hit_rxd;
  assign w_con_wr  = mem_wr & w_hit_con;
  assign w_tx_end  = (r_tx_cnt == DIV_M1);
  assign w_rx_s    = r_rx_sync[1];
  assign w_unused  = ^wdata[31:8];

  // Line value is computed from the next state so uart_tx can be a flop.
  always_comb begin
    w_tx_next     = r_tx_state;
    w_tx_cnt_next = r_tx_cnt;
    w_tx_bit_next = r_tx_bit;
    w_tx_done_set = 1'b0;
    w_tx_line     = 1'b1;
    case (r_tx_state)
      TX_IDLE: if (w_txd_wr) begin
        w_tx_next     = TX_START;
        w_tx_cnt_next = '0;
      end
      TX_START: if (w_tx_end) begin
        w_tx_next     = TX_DATA;
        w_tx_cnt_next = '0;
        w_tx_bit_next = '0;
      end else w_tx_cnt_next = r_tx_cnt + 16'd1;
      TX_DATA: if (w_tx_end) begin
        w_tx_cnt_next = '0;
        if (r_tx_bit == 3'd7) w_tx_next = TX_STOP;
        else w_tx_bit_next = r_tx_bit + 3'd1;
      end else w_tx_cnt_next = r_tx_cnt + 16'd1;
      TX_STOP: if (w_tx_end) begin
        w_tx_next     = TX_IDLE;
        w_tx_cnt_next = '0;
        w_tx_done_set = 1'b1;
      end else w_tx_cnt_next = r_tx_cnt + 16'd1;
      default: w_tx_next = TX_IDLE;
    endcase
    case (w_tx_next)
      TX_START: w_tx_line = 1'b0;
      TX_DATA:  w_tx_line = r_tx_data[w_tx_bit_next];
      default:  w_tx_line = 1'b1;
    endcase
  end

  always_comb begin
    w_rx_next       = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_done       = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!w_rx_s) begin
        w_rx_next     = RX_START;
        w_rx_cnt_next = '0;
      end
      RX_START: if (r_rx_cnt == HALF_M1) begin
        w_rx_cnt_next = '0;
        w_rx_bit_next = '0;
        w_rx_next     = w_rx_s ? RX_IDLE : RX_DATA;
      end else w_rx_cnt_next = r_rx_cnt + 16'd1;
      RX_DATA: if (r_rx_cnt == DIV_M1) begin
        w_rx_cnt_next   = '0;
        w_rx_shift_next = {w_rx_s, r_rx_shift[7:1]};
        if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
        else w_rx_bit_next = r_rx_bit + 3'd1;
      end else w_rx_cnt_next = r_rx_cnt + 16'd1;
      RX_STOP: if (r_rx_cnt == DIV_M1) begin
        w_rx_cnt_next = '0;
        w_rx_next     = RX_IDLE;
        w_rx_done     = w_rx_s;
      end else w_rx_cnt_next = r_rx_cnt + 16'd1;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_rx_state <= RX_IDLE;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_rx_bit   <= '0;
      r_tx_data  <= '0;
      r_rx_data  <= '0;
      r_rx_shift <= '0;
      r_rx_sync  <= 2'b11;
      r_uart_tx  <= 1'b1;
      r_tx_ie    <= 1'b0;
      r_rx_ie    <= 1'b0;
      r_tx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_rx_state <= w_rx_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_sync  <= {r_rx_sync[0], uart_rx};
      r_uart_tx  <= w_tx_line;
      if (w_txd_wr) r_tx_data <= wdata[7:0];
      if (w_con_wr) begin
        r_tx_ie <= wdata[0];
        r_rx_ie <= wdata[1];
      end
      // Completion events win over same-edge clears.
      if (w_tx_done_set) r_tx_done <= 1'b1;
      else if (w_txd_wr || (w_con_wr && wdata[2])) r_tx_done <= 1'b0;
      if (w_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid) r_overrun <= 1'b1;
        else if (w_rxd_rd) r_overrun <= 1'b0;
      end else if (w_rxd_rd) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (mem_rd) begin
      if (w_hit_txd)      rdata = {24'b0, r_tx_data};
      else if (w_hit_rxd) rdata = {24'b0, r_rx_data};
      else if (w_hit_con) rdata = {26'b0, r_overrun, w_tx_busy, r_rx_valid,
                                   r_tx_done, r_rx_ie, r_tx_ie};
    end
  end

  assign uart_tx        = r_uart_tx;
  assign irq            = (r_tx_ie & r_tx_done) | (r_rx_ie & r_rx_valid);
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rx_state = r_rx_state;
endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed scoreboard bench for uart_bus_slave at DIV = 16: stimulus pushes
// expected observations, a negedge monitor pops and compares them.
module tb_uart_bus_slave;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset, mem_rd, mem_wr, uart_rx, uart_tx, irq;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  dbg_tx, dbg_rx;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        obs_valid;
  logic [1:0]  obs_sel;
  logic [31:0] mon_act, mon_exp;
  string       mon_nm;
  int          checks = 0;
  int          errors = 0;
  int          t_off  = 0;
  logic [9:0]  fr;

  uart_bus_slave #(
    .BASE_ADDR(A_TXD), .CLK_FREQ(160_000), .BAUD(10_000)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .irq(irq), .o_dbg_tx_state(dbg_tx),
    .o_dbg_rx_state(dbg_rx)
  );

  always #5 clk = ~clk;

  // Monitor: obs_sel 0 = rdata, 1 = uart_tx, 2 = irq.
  always @(negedge clk) begin
    if (obs_valid) begin
      mon_act = (obs_sel == 2'd0) ? rdata :
                (obs_sel == 2'd1) ? {31'b0, uart_tx} : {31'b0, irq};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_underflow actual %h required <queued value>", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL %s actual %h required %h", mon_nm, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    t_off++;
  endtask

  task automatic goto(input int off);
    while (t_off < off) step();
  endtask

  task automatic expect_obs(input logic [1:0] sel, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    obs_sel   = sel;
    obs_valid = 1'b1;
    step();
    obs_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    addr   = a;
    mem_rd = 1'b1;
    expect_obs(2'd0, e, nm);
    mem_rd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wdata  = d;
    mem_wr = 1'b1;
    step();
    mem_wr = 1'b0;
  endtask

  task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
    wdata  = d;
    mem_wr = 1'b1;
    rd(a, e, nm);
    mem_wr = 1'b0;
  endtask

  task automatic check_line(input logic e, input string nm);
    expect_obs(2'd1, {31'b0, e}, nm);
  endtask

  task automatic check_irq(input logic e, input string nm);
    expect_obs(2'd2, {31'b0, e}, nm);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) step();
    end
    uart_rx = stop;
    repeat (16) step();
    uart_rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
    uart_rx = 1'b1; obs_valid = 1'b0; obs_sel = 2'd0;
    repeat (3) step();
    reset = 1'b0;
    check_line(1'b1, "init_tx");
    check_irq(1'b0, "init_irq");
    rd(A_CON, 32'h0, "init_con");
    rd(A_RXD, 32'h0, "init_rxd");

    // TX frame 0xA5, each bit checked on its first and last cycle.
    wr(A_TXD, 32'hA5);
    t_off = 0;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      goto(16 * k);
      check_line(fr[k], $sformatf("tx_bit%0d_first", k));
      if (k == 1) begin goto(20); rd(A_CON, 32'h10, "con_busy"); end
      if (k == 3) begin goto(50); wr(A_TXD, 32'h3C); end
      if (k == 4) begin goto(70); rd(A_TXD, 32'hA5, "txd_keep"); end
      goto(16 * k + 15);
      check_line(fr[k], $sformatf("tx_bit%0d_last", k));
    end
    goto(160);
    rd(A_CON, 32'h4, "con_done");

    // Interrupt enable and W1C.
    wr(A_CON, 32'h1);
    check_irq(1'b1, "irq_tx");
    wr(A_CON, 32'h5);
    check_irq(1'b0, "irq_w1c");
    rd(A_CON, 32'h1, "con_after_w1c");

    // TXD store in the last STOP cycle is dropped.
    wr(A_TXD, 32'h0F);
    t_off = 0;
    goto(159);
    wr(A_TXD, 32'hF0);
    rd(A_TXD, 32'h0F, "txd_stop_store");
    check_line(1'b1, "no_restart");
    rd(A_CON, 32'h5, "con_done_x");
    check_irq(1'b1, "irq_done_x");

    // Completion on the same edge as a W1C keeps tx_done.
    wr(A_TXD, 32'h81);
    t_off = 0;
    goto(100);
    rd(A_CON, 32'h11, "con_busy_y");
    goto(159);
    wr(A_CON, 32'h5);
    rd(A_CON, 32'h5, "done_beats_w1c");
    check_irq(1'b1, "irq_y");
    wr(A_CON, 32'h4);
    rd(A_CON, 32'h0, "con_cleared");

    // Reset for two cycles mid-frame.
    wr(A_CON, 32'h1);
    wr(A_TXD, 32'h55);
    t_off = 0;
    goto(30);
    reset = 1'b1;
    step();
    check_line(1'b1, "rst_line_during");
    reset = 1'b0;
    check_irq(1'b0, "rst_irq");
    rd(A_CON, 32'h0, "rst_con");
    rd(A_TXD, 32'h0, "rst_txd");
    goto(200);
    check_line(1'b1, "rst_aborted");

    // RX byte with interrupt.
    wr(A_CON, 32'h2);
    send_rx(8'h5A, 1'b1);
    repeat (2) step();
    check_irq(1'b1, "irq_rx");
    rd(A_CON, 32'hA, "con_rxv");
    rd(A_RXD, 32'h5A, "rxd_5a");
    check_irq(1'b0, "irq_rx_clr");
    rd(A_CON, 32'h2, "con_rx_clr");

    // Overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (2) step();
    rd(A_CON, 32'h2A, "con_overrun");
    rd(A_RXD, 32'h22, "rxd_overwrite");
    rd(A_CON, 32'h2, "con_ovr_clr");

    // Short glitch must not start a byte.
    uart_rx = 1'b0;
    repeat (3) step();
    uart_rx = 1'b1;
    repeat (200) step();
    rd(A_CON, 32'h2, "glitch_ignored");

    // Framing error leaves flags and data untouched.
    send_rx(8'hFF, 1'b0);
    repeat (40) step();
    rd(A_CON, 32'h2, "frame_err_con");
    rd(A_RXD, 32'h22, "frame_err_rxd");

    // Simultaneous read and write: read sees pre-edge value.
    rw(A_CON, 32'h3, 32'h2, "rw_pre");
    rd(A_CON, 32'h3, "rw_post");

    repeat (3) step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
